fpad_seq: RTL and testbench

Multi-cycle sequencer for the half-precision-style floating-point adder (sign, 5-bit exponent, 11-bit mantissa with explicit leading one at m[10]). It accepts one add/subtract request at a time over a valid/ready handshake. It steps the operation through compare/swap, alignment, add/subtract and iterative normalisation, then holds the result until the consumer takes it. It owns all sequencing state and replaces the free-running clocked datapath with a deterministic, handshaked unit.

---
 rtl/fpad_seq.sv | 198 +++++++++++++++++++
 tb/tb_fpad_seq.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpad_seq.sv
// Handshaked multi-cycle sequencer for a small floating-point adder
// (sign, 5-bit exponent, 11-bit mantissa with explicit leading one at m[10]).
//
// Handshake contract: a request is taken on a rising edge where in_valid and
// in_ready are both high; a result is taken on a rising edge where out_valid
// and out_ready are both high. Neither side may assume anything else.
module fpad_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        s1,
  input  logic        s2,
  input  logic        op,
  input  logic [4:0]  e1,
  input  logic [4:0]  e2,
  input  logic [10:0] m1,
  input  logic [10:0] m2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sop,
  output logic [4:0]  eop,
  output logic [10:0] mop,
  output logic        ovf,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMP,
    ST_ALIGN,
    ST_ADDSUB,
    ST_NORM,
    ST_DONE
  } state_t;

  state_t      state_q, state_d;

  // Operand A ends up as the larger magnitude after CMP; B carries the
  // effective sign (s2 ^ op) so ADDSUB only has to compare signs.
  logic        a_s_q, a_s_d;
  logic [4:0]  a_e_q, a_e_d;
  logic [10:0] a_m_q, a_m_d;
  logic        b_s_q, b_s_d;
  logic [4:0]  b_e_q, b_e_d;
  logic [10:0] b_m_q, b_m_d;
  logic [4:0]  dist_q, dist_d;
  logic [11:0] sum_q, sum_d;

  logic        res_s_q, res_s_d;
  logic [4:0]  res_e_q, res_e_d;
  logic [10:0] res_m_q, res_m_d;
  logic        ovf_q, ovf_d;

  logic        first_larger;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_s_q   <= 1'b0;
      a_e_q   <= 5'd0;
      a_m_q   <= 11'd0;
      b_s_q   <= 1'b0;
      b_e_q   <= 5'd0;
      b_m_q   <= 11'd0;
      dist_q  <= 5'd0;
      sum_q   <= 12'd0;
      res_s_q <= 1'b0;
      res_e_q <= 5'd0;
      res_m_q <= 11'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_s_q   <= a_s_d;
      a_e_q   <= a_e_d;
      a_m_q   <= a_m_d;
      b_s_q   <= b_s_d;
      b_e_q   <= b_e_d;
      b_m_q   <= b_m_d;
      dist_q  <= dist_d;
      sum_q   <= sum_d;
      res_s_q <= res_s_d;
      res_e_q <= res_e_d;
      res_m_q <= res_m_d;
      ovf_q   <= ovf_d;
    end
  end

  // Ties on exponent and mantissa keep operand 1 as A.
  assign first_larger = (a_e_q > b_e_q) || ((a_e_q == b_e_q) && (a_m_q >= b_m_q));

  always_comb begin
    state_d = state_q;
    a_s_d   = a_s_q;
    a_e_d   = a_e_q;
    a_m_d   = a_m_q;
    b_s_d   = b_s_q;
    b_e_d   = b_e_q;
    b_m_d   = b_m_q;
    dist_d  = dist_q;
    sum_d   = sum_q;
    res_s_d = res_s_q;
    res_e_d = res_e_q;
    res_m_d = res_m_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_s_d   = s1;
          a_e_d   = e1;
          a_m_d   = m1;
          b_s_d   = s2 ^ op;
          b_e_d   = e2;
          b_m_d   = m2;
          state_d = ST_CMP;
        end
      end

      ST_CMP: begin
        if (first_larger) begin
          dist_d = a_e_q - b_e_q;
        end else begin
          a_s_d  = b_s_q;
          a_e_d  = b_e_q;
          a_m_d  = b_m_q;
          b_s_d  = a_s_q;
          b_e_d  = a_e_q;
          b_m_d  = a_m_q;
          dist_d = b_e_q - a_e_q;
        end
        state_d = ST_ALIGN;
      end

      ST_ALIGN: begin
        // Truncating alignment; anything shifted past the LSB is lost.
        b_m_d   = (dist_q >= 5'd11) ? 11'd0 : (b_m_q >> dist_q);
        state_d = ST_ADDSUB;
      end

      ST_ADDSUB: begin
        if (a_s_q == b_s_q) begin
          sum_d = {1'b0, a_m_q} + {1'b0, b_m_q};
        end else begin
          sum_d = {1'b0, a_m_q} - {1'b0, b_m_q};
        end
        state_d = ST_NORM;
      end

      ST_NORM: begin
        // a_e_q doubles as the running result exponent from here on.
        if (sum_q == 12'd0) begin
          res_s_d = 1'b0;
          res_e_d = 5'd0;
          res_m_d = 11'd0;
          ovf_d   = 1'b0;
          state_d = ST_DONE;
        end else if (sum_q[11] && (a_e_q == 5'd31)) begin
          res_s_d = a_s_q;
          res_e_d = 5'd31;
          res_m_d = 11'h7FF;
          ovf_d   = 1'b1;
          state_d = ST_DONE;
        end else if (sum_q[11]) begin
          sum_d = sum_q >> 1;
          a_e_d = a_e_q + 5'd1;
        end else if (!sum_q[10] && (a_e_q != 5'd0)) begin
          sum_d = sum_q << 1;
          a_e_d = a_e_q - 5'd1;
        end else begin
          res_s_d = a_s_q;
          res_e_d = a_e_q;
          res_m_d = sum_q[10:0];
          ovf_d   = 1'b0;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          ovf_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sop       = res_s_q;
  assign eop       = res_e_q;
  assign mop       = res_m_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fpad_seq.sv
// Bench for fpad_seq: directed vector table, handshake/reset sequences and
// random requests checked against an arithmetic reference model.
module tb_fpad_seq;

  localparam int W = 23;  // {sign, exp[4:0], mant[10:0], ovf, latency[4:0]}

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        s1, s2, op;
  logic [4:0]  e1, e2;
  logic [10:0] m1, m2;
  logic        out_valid;
  logic        out_ready;
  logic        sop;
  logic [4:0]  eop;
  logic [10:0] mop;
  logic        ovf;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] exp_q[$];

  typedef struct {
    string       name;
    logic        s1;
    logic [4:0]  e1;
    logic [10:0] m1;
    logic        s2;
    logic [4:0]  e2;
    logic [10:0] m2;
    logic        op;
    logic        xs;
    logic [4:0]  xe;
    logic [10:0] xm;
    logic        xo;
    int          xl;
  } vec_t;

  vec_t tbl[$];

  fpad_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s1        (s1),
    .s2        (s2),
    .op        (op),
    .e1        (e1),
    .e2        (e2),
    .m1        (m1),
    .m2        (m2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sop       (sop),
    .eop       (eop),
    .mop       (mop),
    .ovf       (ovf),
    .busy      (busy)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: compare/swap, truncating alignment, signed-magnitude add,
  // then normalise the magnitude into [1024, 2048) by powers of two.
  function automatic logic [W-1:0] model(input logic as_, input int ae, input int am,
                                         input logic bs_, input int be, input int bm,
                                         input logic o);
    int   ea, eb, ma, mb, sum, e, m, n, d;
    logic sa, sb, s, ov, fin;
    if (ae > be || (ae == be && am >= bm)) begin
      sa = as_;     ea = ae; ma = am;
      sb = bs_ ^ o; eb = be; mb = bm;
    end else begin
      sa = bs_ ^ o; ea = be; ma = bm;
      sb = as_;     eb = ae; mb = am;
    end
    d   = ea - eb;
    mb  = (d >= 11) ? 0 : mb / (1 << d);
    sum = (sa == sb) ? ma + mb : ma - mb;
    e = ea; s = sa; m = 0; n = 0; ov = 1'b0; fin = 1'b0;
    for (int k = 0; k < 16 && !fin; k++) begin
      if (sum == 0) begin
        s = 1'b0; e = 0; m = 0; fin = 1'b1;
      end else if (sum >= 2048 && e == 31) begin
        ov = 1'b1; m = 2047; fin = 1'b1;
      end else if (sum >= 2048) begin
        sum = sum / 2; e = e + 1; n++;
      end else if (sum < 1024 && e > 0) begin
        sum = sum * 2; e = e - 1; n++;
      end else begin
        m = sum; fin = 1'b1;
      end
    end
    return {s, 5'(e), 11'(m), ov, 5'(4 + n)};
  endfunction

  // ---------------- driver ----------------
  task automatic run_op(input string nm,
                        input logic a_s, input logic [4:0] a_e, input logic [10:0] a_m,
                        input logic b_s, input logic [4:0] b_e, input logic [10:0] b_m,
                        input logic o, input logic consume, input logic rand_ready);
    logic [W-1:0] x;
    int cyc;
    x = exp_q.pop_front();
    @(negedge clk);
    chk({nm, ".in_ready_idle"}, in_ready, 1);
    s1 = a_s; e1 = a_e; m1 = a_m;
    s2 = b_s; e2 = b_e; m2 = b_m;
    op = o;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
    chk({nm, ".busy"}, busy, 1);
    chk({nm, ".in_ready_busy"}, in_ready, 0);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    out_ready = 1'b0;
    if (!out_valid) begin
      chk({nm, ".timeout"}, 32'(cyc), 32'(x[4:0]));
      return;
    end
    chk({nm, ".latency"}, 32'(cyc), 32'(x[4:0]));
    chk({nm, ".sop"}, sop, x[22]);
    chk({nm, ".eop"}, eop, x[21:17]);
    chk({nm, ".mop"}, mop, x[16:6]);
    chk({nm, ".ovf"}, ovf, x[5]);
    if (consume) begin
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({nm, ".in_ready_after"}, in_ready, 1);
      chk({nm, ".out_valid_after"}, out_valid, 0);
      chk({nm, ".ovf_after"}, ovf, 0);
    end
  endtask

  task automatic add_vec(input string nm,
                         input logic a_s, input logic [4:0] a_e, input logic [10:0] a_m,
                         input logic b_s, input logic [4:0] b_e, input logic [10:0] b_m,
                         input logic o,
                         input logic xs, input logic [4:0] xe, input logic [10:0] xm,
                         input logic xo, input int xl);
    vec_t v;
    v.name = nm; v.s1 = a_s; v.e1 = a_e; v.m1 = a_m;
    v.s2 = b_s; v.e2 = b_e; v.m2 = b_m; v.op = o;
    v.xs = xs; v.xe = xe; v.xm = xm; v.xo = xo; v.xl = xl;
    tbl.push_back(v);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic        rs1, rs2, rop;
    logic [4:0]  re1, re2;
    logic [10:0] rm1, rm2;
    int          t;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    s1 = 0; s2 = 0; op = 0; e1 = 0; e2 = 0; m1 = 0; m2 = 0;

    //                name          s1 e1  m1      s2 e2  m2      op  xs xe  xm      xo lat
    add_vec("one_plus_one", 0, 15, 11'h400, 0, 15, 11'h400, 0,  0, 16, 11'h400, 0, 5);
    add_vec("x_minus_x",    0, 15, 11'h400, 0, 15, 11'h400, 1,  0, 0,  11'h000, 0, 4);
    add_vec("p15_m125",     0, 15, 11'h600, 0, 15, 11'h500, 1,  0, 13, 11'h400, 0, 6);
    add_vec("p10_m15",      0, 15, 11'h400, 0, 15, 11'h600, 1,  1, 14, 11'h400, 0, 5);
    add_vec("align_d2",     0, 15, 11'h400, 0, 13, 11'h400, 0,  0, 15, 11'h500, 0, 4);
    add_vec("align_d20",    0, 30, 11'h5A3, 0, 10, 11'h400, 0,  0, 30, 11'h5A3, 0, 4);
    add_vec("overflow",     0, 31, 11'h7FF, 0, 31, 11'h7FF, 0,  0, 31, 11'h7FF, 1, 4);
    add_vec("neg_plus_neg", 1, 15, 11'h400, 1, 15, 11'h400, 0,  1, 16, 11'h400, 0, 5);
    add_vec("sub_negative", 0, 15, 11'h400, 1, 15, 11'h400, 1,  0, 16, 11'h400, 0, 5);
    add_vec("underflow",    0, 1,  11'h600, 0, 1,  11'h500, 1,  0, 0,  11'h200, 0, 5);

    // Reset values while rst_n is held low.
    #2;
    chk("rst.out_valid", out_valid, 0);
    chk("rst.in_ready", in_ready, 1);
    chk("rst.busy", busy, 0);
    chk("rst.sop", sop, 0);
    chk("rst.eop", eop, 0);
    chk("rst.mop", mop, 0);
    chk("rst.ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < tbl.size(); i++) begin
      exp_q.push_back({tbl[i].xs, tbl[i].xe, tbl[i].xm, tbl[i].xo, 5'(tbl[i].xl)});
      run_op(tbl[i].name, tbl[i].s1, tbl[i].e1, tbl[i].m1, tbl[i].s2, tbl[i].e2,
             tbl[i].m2, tbl[i].op, 1'b1, 1'b1);
    end

    // Hold the result for 10 cycles while a second request is offered.
    exp_q.push_back({1'b0, 5'd16, 11'h400, 1'b0, 5'd5});
    run_op("hold", 0, 15, 11'h400, 0, 15, 11'h400, 0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      s1 = 1; e1 = 5'd3; m1 = 11'h555; s2 = 0; e2 = 5'd7; m2 = 11'h6AA; op = 1;
      @(posedge clk);
      #1;
      chk("hold.out_valid", out_valid, 1);
      chk("hold.in_ready", in_ready, 0);
      chk("hold.sop", sop, 0);
      chk("hold.eop", eop, 16);
      chk("hold.mop", mop, 11'h400);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("hold.released", in_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("hold.no_queue_valid", out_valid, 0);
    chk("hold.no_queue_ready", in_ready, 1);

    // Reset in the middle of normalisation (1.5 - 1.25 normalises for 2 cycles).
    @(negedge clk);
    s1 = 0; e1 = 15; m1 = 11'h600; s2 = 0; e2 = 15; m2 = 11'h500; op = 1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midnorm.busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midnorm.out_valid", out_valid, 0);
    chk("midnorm.in_ready", in_ready, 1);
    chk("midnorm.busy", busy, 0);
    chk("midnorm.eop", eop, 0);
    chk("midnorm.mop", mop, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back({1'b0, 5'd13, 11'h400, 1'b0, 5'd6});
    run_op("after_reset", 0, 15, 11'h600, 0, 15, 11'h500, 1, 1'b1, 1'b1);

    // Random requests against the reference model.
    for (int i = 0; i < 60; i++) begin
      rs1 = 1'($urandom_range(0, 1));
      rs2 = 1'($urandom_range(0, 1));
      rop = 1'($urandom_range(0, 1));
      re1 = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) begin
        t = int'(re1) + $urandom_range(0, 2) - 1;
        if (t < 0) t = 0;
        if (t > 31) t = 31;
        re2 = 5'(t);
      end else begin
        re2 = 5'($urandom_range(0, 31));
      end
      rm1 = 11'h400 | 11'($urandom_range(0, 1023));
      rm2 = ($urandom_range(0, 3) == 0) ? rm1 : (11'h400 | 11'($urandom_range(0, 1023)));
      exp_q.push_back(model(rs1, int'(re1), int'(rm1), rs2, int'(re2), int'(rm2), rop));
      run_op($sformatf("rand%0d", i), rs1, re1, rm1, rs2, re2, rm2, rop, 1'b1, 1'b1);
    end

    chk("scoreboard.empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
